// File: rtl/riscv_pkg.sv
// Shared core-wide widths, reset vector and the fetch-to-decode packet layout.
// Contains no logic, so it has no latency and no backpressure.
package riscv_pkg;
   localparam int                 XLEN      = 32;
   localparam logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000;
   localparam int                 INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_pkt_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush. head_dat is combinational from the head entry (0-cycle read).
// Backpressure is the caller's job via count; a flush overrides any push or pop in the same cycle.
module sync_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = XLEN + INSTR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) store[wr_ptr_q] <= push_dat;
   end

   assign head_dat = store[rd_ptr_q];
   assign count    = count_q;

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      !(pop && !flush && count_q == '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && !flush && count_q == DEPTH_C));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers {pc, instr} for decode.
// Request to id_valid is 2 cycles with 1-cycle imem; id_ready low holds the head and stops requests once DEPTH slots are used.
module fetch_stage #(
   parameter int                 XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]    RESET_PC = riscv_pkg::RESET_PC,
   parameter int                 DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [XLEN-1:0]   id_pc,
   output logic [31:0]       id_instr
);
   import riscv_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = XLEN + INSTR_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   buf_count, pcq_count, used;
   logic [XLEN-1:0] pcq_head;
   logic [PW-1:0]   buf_head;
   logic            buf_vld, id_pop, req_acc, rsp_keep;

   always_comb begin
      buf_vld  = (buf_count != '0);
      id_pop   = buf_vld && id_ready;
      // A slot freed by this cycle's decode pop can be reused at once, giving 1 instr/cycle at DEPTH=2.
      used     = outstanding_q + buf_count - CW'(id_pop);
      imem_req_valid = rst && (used < DEPTH_C) && !redirect_valid;
      imem_req_addr  = pc_q;
      req_acc  = imem_req_valid && imem_req_ready;
      rsp_keep = imem_rsp_valid && !redirect_valid && (discard_q == '0) && (pcq_count != '0);
      id_valid = buf_vld;
      id_pc    = buf_vld ? buf_head[PW-1 -: XLEN] : '0;
      id_instr = buf_vld ? buf_head[INSTR_W-1:0] : '0;
   end

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CW'(req_acc) - CW'(imem_rsp_valid);
      discard_d     = discard_q;
      if (redirect_valid) begin
         // Every fetch still in flight after this cycle belongs to the dead path.
         pc_d      = redirect_pc & ~XLEN'(3);
         discard_d = outstanding_q - CW'(imem_rsp_valid);
      end else begin
         if (req_acc) pc_d = pc_q + XLEN'(4);
         if (imem_rsp_valid && discard_q != '0) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (req_acc),
      .push_dat (pc_q),
      .pop      (rsp_keep),
      .flush    (redirect_valid),
      .head_dat (pcq_head),
      .count    (pcq_count)
   );

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(PW)) u_fetch_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (rsp_keep),
      .push_dat ({pcq_head, imem_rsp_data}),
      .pop      (id_pop && !redirect_valid),
      .flush    (redirect_valid),
      .head_dat (buf_head),
      .count    (buf_count)
   );

   a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outstanding_q != '0));
   a_pcq_tracks: assert property (@(posedge clk) disable iff (!rst)
      (pcq_count + discard_q) == outstanding_q);
endmodule
